noc_traffic_node: RTL and testbench

- Synthesizable, parametrised traffic endpoint for one mesh node; replaces hand-written per-node stimulus loops in NoC benches.
- Injection side: FSM emits N packets of configurable length and destination, with gaps between them, on the router local input port. Uses a valid/ready handshake.
- Ejection side: sinks flits from the router local output port, checks flit-type sequencing, destination and payload, and keeps packet and flit counters.
- One instance attaches to each Node<k> port pair of a MeshXY top.

---
 rtl/noc_pkg.sv | 46 ++++
 rtl/noc_rx_checker.sv | 113 +++++++++++
 rtl/noc_traffic_node.sv | 206 ++++++++++++++++++++
 tb/tb_noc_traffic_node.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC traffic endpoint: flit types, type-field
// position helpers, error codes and FSM state encodings.
package noc_pkg;

    // Two-bit flit type carried in the top bits of every flit
    typedef enum logic [1:0] {
        FLIT_ILLEGAL = 2'b00,
        FLIT_HEAD    = 2'b01,
        FLIT_BODY    = 2'b10,
        FLIT_TAIL    = 2'b11
    } flit_type_e;

    localparam int FLIT_TYPE_WIDTH = 2;

    // Bit positions of the type field for a given flit width
    function automatic int flit_type_hi(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int flit_type_lo(input int data_width);
        return data_width - FLIT_TYPE_WIDTH;
    endfunction

    // Error codes reported by the ejection checker (first error wins)
    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_NO_HEAD     = 3'd1;
    localparam logic [2:0] ERR_HEAD_IN_PKT = 3'd2;
    localparam logic [2:0] ERR_DEST        = 3'd3;
    localparam logic [2:0] ERR_PAYLOAD     = 3'd4;
    localparam logic [2:0] ERR_ILLEGAL     = 3'd5;

    // Injection FSM states
    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY,
        GAP
    } tx_state_e;

    // Ejection checker states
    typedef enum logic {
        R_IDLE,
        R_PKT
    } rx_state_e;

endpackage

// File: rtl/noc_rx_checker.sv
// Ejection-side checker: follows head/body/tail sequencing, checks the
// destination and payload index, counts flits and packets, and latches the
// first error seen.
module noc_rx_checker
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int NODE_ID      = 0,
    parameter int PAYLOAD_BASE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  accept,
    output logic [15:0]           rx_pkt_count,
    output logic [15:0]           rx_flit_count,
    output logic                  err_flag,
    output logic [2:0]            err_code
);

    localparam int TYPE_HI = flit_type_hi(DATA_WIDTH);
    localparam int TYPE_LO = flit_type_lo(DATA_WIDTH);

    rx_state_e   state, state_n;
    logic [15:0] exp_idx, exp_idx_n;
    logic        err_hit;
    logic [2:0]  err_val;
    logic        pkt_inc;
    flit_type_e  ftype;
    logic        dest_ok;
    logic        payload_ok;
    logic        unused_bits;

    assign ftype       = flit_type_e'(rx_data[TYPE_HI:TYPE_LO]);
    assign dest_ok     = (rx_data[ADDR_WIDTH-1:0] == ADDR_WIDTH'(NODE_ID));
    assign payload_ok  = (rx_data[15:0] == (16'(PAYLOAD_BASE) + exp_idx));
    assign unused_bits = ^rx_data[TYPE_LO-1:16];

    // Next-state, expected index and error detection for one accepted flit
    always_comb begin
        state_n   = state;
        exp_idx_n = exp_idx;
        err_hit   = 1'b0;
        err_val   = ERR_NONE;
        pkt_inc   = 1'b0;
        if (accept) begin
            case (ftype)
                FLIT_HEAD: begin
                    if (state == R_PKT) begin
                        err_hit = 1'b1;
                        err_val = ERR_HEAD_IN_PKT;
                    end else if (!dest_ok) begin
                        err_hit = 1'b1;
                        err_val = ERR_DEST;
                    end
                    state_n   = R_PKT;
                    exp_idx_n = 16'd2;
                end
                FLIT_BODY, FLIT_TAIL: begin
                    if (state == R_IDLE) begin
                        err_hit = 1'b1;
                        err_val = ERR_NO_HEAD;
                    end else begin
                        if (ftype == FLIT_TAIL) begin
                            pkt_inc = 1'b1;
                        end
                        if (!payload_ok) begin
                            err_hit = 1'b1;
                            err_val = ERR_PAYLOAD;
                            state_n = R_IDLE;
                        end else if (ftype == FLIT_TAIL) begin
                            state_n = R_IDLE;
                        end else begin
                            exp_idx_n = exp_idx + 16'd1;
                        end
                    end
                end
                default: begin
                    err_hit = 1'b1;
                    err_val = ERR_ILLEGAL;
                    state_n = R_IDLE;
                end
            endcase
        end
    end

    // Checker state, counters and sticky first-error capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= R_IDLE;
            exp_idx       <= '0;
            rx_pkt_count  <= '0;
            rx_flit_count <= '0;
            err_flag      <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            state   <= state_n;
            exp_idx <= exp_idx_n;
            if (accept) begin
                rx_flit_count <= rx_flit_count + 16'd1;
            end
            if (pkt_inc) begin
                rx_pkt_count <= rx_pkt_count + 16'd1;
            end
            if (err_hit && !err_flag) begin
                err_flag <= 1'b1;
                err_code <= err_val;
            end
        end
    end

endmodule

// File: rtl/noc_traffic_node.sv
// Traffic endpoint for one mesh node: injects a configurable burst of
// packets into the router local port and checks traffic ejected from it.
module noc_traffic_node
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int NODE_ID      = 0,
    parameter int LEN_WIDTH    = 5,
    parameter int PAYLOAD_BASE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_dest,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [15:0]           cfg_num_pkts,
    input  logic [7:0]            cfg_gap,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  sink_stall,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           tx_pkt_count,
    output logic [15:0]           rx_pkt_count,
    output logic [15:0]           rx_flit_count,
    output logic                  err_flag,
    output logic [2:0]            err_code
);

    localparam int TYPE_HI = flit_type_hi(DATA_WIDTH);
    localparam int TYPE_LO = flit_type_lo(DATA_WIDTH);

    tx_state_e             state, state_n;
    logic                  tx_valid_n;
    logic [DATA_WIDTH-1:0] tx_data_n;
    logic [LEN_WIDTH-1:0]  idx, idx_n;
    logic [LEN_WIDTH-1:0]  len_q, len_n;
    logic [ADDR_WIDTH-1:0] dest_q, dest_n;
    logic [7:0]            gap_q, gap_n;
    logic [7:0]            gap_cnt, gap_cnt_n;
    logic [15:0]           pkts_left, pkts_left_n;
    logic [15:0]           tx_pkt_count_n;
    logic [7:0]            seq, seq_n;
    logic                  done_n;
    logic                  tx_fire;
    logic                  rx_accept;

    assign tx_fire   = tx_valid && tx_ready;
    assign busy      = (state != IDLE);
    assign rx_ready  = ~sink_stall;
    assign rx_accept = rx_valid && rx_ready;

    function automatic logic [DATA_WIDTH-1:0] head_flit(input logic [ADDR_WIDTH-1:0] dest);
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[TYPE_HI:TYPE_LO] = FLIT_HEAD;
        f[2*ADDR_WIDTH-1:ADDR_WIDTH] = ADDR_WIDTH'(NODE_ID);
        f[ADDR_WIDTH-1:0] = dest;
        return f;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] body_flit(input logic [LEN_WIDTH-1:0] i,
                                                         input logic last,
                                                         input logic [7:0] s);
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[TYPE_HI:TYPE_LO] = last ? FLIT_TAIL : FLIT_BODY;
        f[23:16] = s;
        f[15:0]  = 16'(PAYLOAD_BASE) + 16'(i);
        return f;
    endfunction

    // Injection FSM: next state and next registered flit/valid
    always_comb begin
        state_n        = state;
        tx_valid_n     = tx_valid;
        tx_data_n      = tx_data;
        idx_n          = idx;
        len_n          = len_q;
        dest_n         = dest_q;
        gap_n          = gap_q;
        gap_cnt_n      = gap_cnt;
        pkts_left_n    = pkts_left;
        tx_pkt_count_n = tx_pkt_count;
        seq_n          = seq;
        done_n         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_num_pkts == 16'd0) begin
                        done_n = 1'b1;
                    end else begin
                        len_n       = (cfg_len < LEN_WIDTH'(2)) ? LEN_WIDTH'(2) : cfg_len;
                        dest_n      = cfg_dest;
                        gap_n       = cfg_gap;
                        pkts_left_n = cfg_num_pkts;
                        seq_n       = 8'd0;
                        state_n     = HEAD;
                        tx_valid_n  = 1'b1;
                        tx_data_n   = head_flit(cfg_dest);
                    end
                end
            end
            HEAD: begin
                if (tx_fire) begin
                    idx_n     = LEN_WIDTH'(2);
                    tx_data_n = body_flit(LEN_WIDTH'(2), (len_q == LEN_WIDTH'(2)), seq);
                    state_n   = BODY;
                end
            end
            BODY: begin
                if (tx_fire) begin
                    if (idx == len_q) begin
                        tx_pkt_count_n = tx_pkt_count + 16'd1;
                        pkts_left_n    = pkts_left - 16'd1;
                        seq_n          = seq + 8'd1;
                        if (pkts_left == 16'd1) begin
                            state_n    = IDLE;
                            tx_valid_n = 1'b0;
                            tx_data_n  = '0;
                            done_n     = 1'b1;
                        end else if (gap_q == 8'd0) begin
                            state_n   = HEAD;
                            tx_data_n = head_flit(dest_q);
                        end else begin
                            state_n    = GAP;
                            tx_valid_n = 1'b0;
                            tx_data_n  = '0;
                            gap_cnt_n  = gap_q;
                        end
                    end else begin
                        idx_n     = idx + LEN_WIDTH'(1);
                        tx_data_n = body_flit(idx + LEN_WIDTH'(1), (idx + LEN_WIDTH'(1) == len_q), seq);
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_n    = HEAD;
                    tx_valid_n = 1'b1;
                    tx_data_n  = head_flit(dest_q);
                end else begin
                    gap_cnt_n = gap_cnt - 8'd1;
                end
            end
            default: begin
                state_n    = IDLE;
                tx_valid_n = 1'b0;
                tx_data_n  = '0;
            end
        endcase
    end

    // Injection FSM state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            idx          <= '0;
            len_q        <= '0;
            dest_q       <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            pkts_left    <= '0;
            tx_pkt_count <= '0;
            seq          <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            tx_valid     <= tx_valid_n;
            tx_data      <= tx_data_n;
            idx          <= idx_n;
            len_q        <= len_n;
            dest_q       <= dest_n;
            gap_q        <= gap_n;
            gap_cnt      <= gap_cnt_n;
            pkts_left    <= pkts_left_n;
            tx_pkt_count <= tx_pkt_count_n;
            seq          <= seq_n;
            done         <= done_n;
        end
    end

    noc_rx_checker #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NODE_ID      (NODE_ID),
        .PAYLOAD_BASE (PAYLOAD_BASE)
    ) u_rx_checker (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .accept        (rx_accept),
        .rx_pkt_count  (rx_pkt_count),
        .rx_flit_count (rx_flit_count),
        .err_flag      (err_flag),
        .err_code      (err_code)
    );

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: loopback and randomized injection against a
// packet-list model, plus a vector table driving the ejection checker.
module tb_noc_traffic_node;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int NID = 7;
    localparam int LW  = 5;
    localparam int PB  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_dest;
    logic [LW-1:0] cfg_len;
    logic [15:0]   cfg_num_pkts;
    logic [7:0]    cfg_gap;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          sink_stall;
    logic          busy;
    logic          done;
    logic [15:0]   tx_pkt_count;
    logic [15:0]   rx_pkt_count;
    logic [15:0]   rx_flit_count;
    logic          err_flag;
    logic [2:0]    err_code;

    logic          loop_en;
    logic [DW-1:0] drv_rx_data;
    logic          drv_rx_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    int  cur_gap     = 0;
    int  ready_mode  = 0;
    bit  mon_en      = 0;
    bit  prev_hold   = 0;
    logic [31:0] prev_data = '0;
    bit  after_tail  = 0;
    int  idle_run    = 0;
    int  exp_tx_pkts = 0;
    int  exp_rx_pkts = 0;
    int  exp_rx_flits = 0;

    typedef struct {
        bit          do_reset;
        logic [31:0] data;
        bit          valid;
        bit          stall;
        int          flits;
        int          pkts;
        int          err;
    } rx_vec_t;

    rx_vec_t vecs[$];

    assign rx_data  = loop_en ? tx_data : drv_rx_data;
    assign rx_valid = loop_en ? (tx_valid && tx_ready) : drv_rx_valid;

    always #5 clk = ~clk;

    noc_traffic_node #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .NODE_ID      (NID),
        .LEN_WIDTH    (LW),
        .PAYLOAD_BASE (PB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_dest      (cfg_dest),
        .cfg_len       (cfg_len),
        .cfg_num_pkts  (cfg_num_pkts),
        .cfg_gap       (cfg_gap),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .sink_stall    (sink_stall),
        .busy          (busy),
        .done          (done),
        .tx_pkt_count  (tx_pkt_count),
        .rx_pkt_count  (rx_pkt_count),
        .rx_flit_count (rx_flit_count),
        .err_flag      (err_flag),
        .err_code      (err_code)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected flit from the packet format rules: flit 1 is the head
    function automatic logic [31:0] model_flit(input int p, input int i, input int len, input int dest);
        logic [31:0] f;
        if (i == 1) begin
            f = (32'd1 << 30) | (32'(NID) << 4) | 32'(dest);
        end else begin
            f = (32'((i == len) ? 3 : 2) << 30) | (32'(p % 256) << 16) | 32'((PB + i) % 65536);
        end
        return f;
    endfunction

    function automatic rx_vec_t vec(input bit r, input logic [31:0] d, input bit v, input bit s,
                                    input int fl, input int pk, input int er);
        rx_vec_t x;
        x.do_reset = r; x.data = d; x.valid = v; x.stall = s;
        x.flits = fl; x.pkts = pk; x.err = er;
        return x;
    endfunction

    // Ready pattern driven just after each rising edge
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Transfer monitor: compares every tx handshake against the model queue
    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en) begin
            if (prev_hold) begin
                checkOutput("hold_valid", tx_valid, 1);
                checkOutput("hold_data", tx_data, prev_data);
            end
            if (after_tail) begin
                if (!tx_valid) idle_run++;
                else begin
                    checkOutput("gap_cycles", idle_run, cur_gap);
                    after_tail = 0;
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_flit: got 0x%0h, expected no flit", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tx_flit", tx_data, e);
                    checkOutput("busy_during_tx", busy, 1);
                    if (e[31:30] == 2'b11 && exp_q.size() > 0) begin
                        after_tail = 1;
                        idle_run = 0;
                    end
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end else begin
            prev_hold  = 0;
            after_tail = 0;
        end
    end

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_tx_pkts = 0; exp_rx_pkts = 0; exp_rx_flits = 0;
    endtask

    // One injection run: builds the expected flit list, starts, waits for done
    task automatic applyStimulus(input int dest, input int len, input int num, input int gap, input int mode);
        int L, cycles, extra_done;
        bit busy_seen, valid_seen;
        L = (len < 2) ? 2 : len;
        for (int p = 0; p < num; p++)
            for (int i = 1; i <= L; i++)
                exp_q.push_back(model_flit(p, i, L, dest));
        cur_gap = gap;
        ready_mode = mode;
        mon_en = 1;
        @(posedge clk); #1;
        cfg_dest = AW'(dest); cfg_len = LW'(len); cfg_num_pkts = 16'(num); cfg_gap = 8'(gap);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_dest = AW'($urandom); cfg_len = LW'($urandom); cfg_num_pkts = 16'($urandom); cfg_gap = 8'($urandom);
        cycles = 0; busy_seen = 0; valid_seen = 0;
        while (cycles < 3000) begin
            @(negedge clk);
            busy_seen  |= busy;
            valid_seen |= tx_valid;
            if (done) break;
            cycles++;
        end
        if (cycles >= 3000) begin
            n_checks++;
            $display("[TB] FAIL done_timeout: got no done within 3000 cycles, expected done");
            exp_q.delete();
        end else begin
            exp_tx_pkts += num;
            if (loop_en) begin
                exp_rx_pkts  += num;
                exp_rx_flits += num * L;
            end
            if (mode == 0)
                checkOutput("done_latency", cycles, (num == 0) ? 0 : num * L + (num - 1) * gap);
            checkOutput("busy_at_done", busy, 0);
            if (num == 0) begin
                checkOutput("busy_num0", busy_seen, 0);
                checkOutput("valid_num0", valid_seen, 0);
            end
            extra_done = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (done) extra_done++;
            end
            checkOutput("done_single", extra_done, 0);
            checkOutput("flits_left", exp_q.size(), 0);
            checkOutput("tx_pkt_count", tx_pkt_count, 64'(exp_tx_pkts % 65536));
            if (loop_en) begin
                checkOutput("rx_pkt_count", rx_pkt_count, 64'(exp_rx_pkts % 65536));
                checkOutput("rx_flit_count", rx_flit_count, 64'(exp_rx_flits % 65536));
                checkOutput("err_code_clean", err_code, 0);
            end
        end
        mon_en = 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nx;
        bit valid_seen;
        rst = 1'b0; start = 1'b0; sink_stall = 1'b0; loop_en = 1'b1; tx_ready = 1'b1;
        cfg_dest = '0; cfg_len = '0; cfg_num_pkts = '0; cfg_gap = '0;
        drv_rx_data = '0; drv_rx_valid = 1'b0;

        // Reset values, and rx_ready tracking sink_stall during reset
        @(negedge clk);
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_counts", {tx_pkt_count, rx_pkt_count, rx_flit_count}, 0);
        checkOutput("rst_err", {err_flag, err_code}, 0);
        checkOutput("rst_rx_ready_hi", rx_ready, 1);
        sink_stall = 1'b1;
        #1 checkOutput("rst_rx_ready_lo", rx_ready, 0);
        sink_stall = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // Directed loopback runs
        applyStimulus(7, 6, 2, 0, 0);
        applyStimulus(7, 6, 2, 0, 1);
        applyStimulus(7, 2, 2, 3, 0);
        applyStimulus(7, 0, 3, 2, 0);
        applyStimulus(7, 5, 0, 1, 0);

        // Reset asserted after the third transferred flit
        doReset();
        ready_mode = 0;
        @(posedge clk); #1;
        cfg_dest = 4'd7; cfg_len = 5'd6; cfg_num_pkts = 16'd2; cfg_gap = 8'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        nx = 0;
        for (int k = 0; k < 50 && nx < 3; k++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) nx++;
        end
        checkOutput("mid_flits_seen", nx, 3);
        @(posedge clk); #1;
        rst = 1'b0; sink_stall = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_tx_valid", tx_valid, 0);
        checkOutput("mid_rst_tx_data", tx_data, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_counts", {tx_pkt_count, rx_flit_count}, 0);
        checkOutput("mid_rst_rx_ready_lo", rx_ready, 0);
        @(posedge clk); #1 sink_stall = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_rx_ready_hi", rx_ready, 1);
        @(posedge clk); #1 rst = 1'b1;
        exp_tx_pkts = 0; exp_rx_pkts = 0; exp_rx_flits = 0;
        valid_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_seen |= tx_valid;
        end
        checkOutput("post_rst_quiet", valid_seen, 0);
        applyStimulus(7, 6, 1, 0, 0);

        // Randomized loopback runs
        for (int r = 0; r < 12; r++)
            applyStimulus(7, $urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 2));

        // Randomized destinations with the ejection side disconnected
        loop_en = 1'b0;
        for (int r = 0; r < 4; r++)
            applyStimulus($urandom_range(0, 15), $urandom_range(2, 9), $urandom_range(1, 3), $urandom_range(0, 2), 2);
        checkOutput("rx_untouched", rx_flit_count, 64'(exp_rx_flits % 65536));

        // Ejection checker vector table
        vecs.push_back(vec(1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(vec(0, 32'h40000077, 1, 0, 1, 0, 0));
        vecs.push_back(vec(0, 32'h80000012, 1, 0, 2, 0, 0));
        vecs.push_back(vec(0, 32'h80000013, 1, 1, 2, 0, 0));
        vecs.push_back(vec(0, 32'h80000013, 1, 0, 3, 0, 0));
        vecs.push_back(vec(0, 32'h80000099, 0, 0, 3, 0, 0));
        vecs.push_back(vec(0, 32'hC0000014, 1, 0, 4, 1, 0));
        vecs.push_back(vec(0, 32'h80000012, 1, 0, 5, 1, 1));
        vecs.push_back(vec(0, 32'h40000077, 1, 0, 6, 1, 1));
        vecs.push_back(vec(0, 32'h80000013, 1, 0, 7, 1, 1));
        vecs.push_back(vec(1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(vec(0, 32'h40000074, 1, 0, 1, 0, 3));
        vecs.push_back(vec(1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(vec(0, 32'h40000077, 1, 0, 1, 0, 0));
        vecs.push_back(vec(0, 32'h80000013, 1, 0, 2, 0, 4));
        vecs.push_back(vec(0, 32'h40000077, 1, 0, 3, 0, 4));
        vecs.push_back(vec(0, 32'hC0000012, 1, 0, 4, 1, 4));
        vecs.push_back(vec(1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(vec(0, 32'h40000077, 1, 0, 1, 0, 0));
        vecs.push_back(vec(0, 32'h00000012, 1, 0, 2, 0, 5));
        vecs.push_back(vec(1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(vec(0, 32'h40000077, 1, 0, 1, 0, 0));
        vecs.push_back(vec(0, 32'h40000077, 1, 0, 2, 0, 2));

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].do_reset) begin
                doReset();
            end else begin
                @(posedge clk); #1;
                drv_rx_data  = vecs[v].data;
                drv_rx_valid = vecs[v].valid;
                sink_stall   = vecs[v].stall;
                @(negedge clk);
                checkOutput($sformatf("vec%0d_rx_ready", v), rx_ready, !vecs[v].stall);
                @(posedge clk); #1;
                drv_rx_valid = 1'b0;
                sink_stall   = 1'b0;
            end
            @(negedge clk);
            checkOutput($sformatf("vec%0d_flits", v), rx_flit_count, vecs[v].flits);
            checkOutput($sformatf("vec%0d_pkts", v), rx_pkt_count, vecs[v].pkts);
            checkOutput($sformatf("vec%0d_err_code", v), err_code, vecs[v].err);
            checkOutput($sformatf("vec%0d_err_flag", v), err_flag, (vecs[v].err != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
